// File: rtl/dmem_arbiter_if.sv
// Bundles the core port, host port and data-memory side of the arbiter.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface dmem_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          c_stall;

  logic          h_req;
  logic          h_lock;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt;
  logic          h_rvalid;
  logic [DW-1:0] h_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata, c_stall,
    input  h_req, h_lock, h_we, h_addr, h_wdata,
    output h_gnt, h_rvalid, h_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata, c_stall,
    output h_req, h_lock, h_we, h_addr, h_wdata,
    input  h_gnt, h_rvalid, h_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the core and a host loader.
// Round-robin grants, with a bounded host burst lock that yields to a waiting core.
module dmem_arbiter #(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 8,
  parameter int SCW      = 16
) (
  input  logic           CLK,
  input  logic           RST,
  dmem_arbiter_if.slave  bus,
  output logic [SCW-1:0] stall_cnt,
  output logic           lock_active
);

  localparam int LCW = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);

  typedef enum logic [1:0] {RR, LOCKED, YIELD} state_e;

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           c_rvalid_q, h_rvalid_q;
  logic [DW-1:0]  c_rdata_q, h_rdata_q;
  logic [SCW-1:0] stall_cnt_q;
  logic           c_win, h_win, rr_c, rr_h;
  logic [AW-1:0]  mem_addr_d;
  logic [DW-1:0]  mem_wdata_d;
  logic           mem_we_d;

  // last_q = 1 means the host had the most recent grant, so the core wins a tie.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    rr_c       = bus.c_req & (~bus.h_req | last_q);
    rr_h       = bus.h_req & ~rr_c;
    c_win      = 1'b0;
    h_win      = 1'b0;
    case (state_q)
      RR: begin
        c_win = rr_c;
        h_win = rr_h;
        if (rr_h && bus.h_lock) begin
          state_d    = LOCKED;
          lock_cnt_d = LCW'(1);
        end
      end
      LOCKED: begin
        if (!(bus.h_req && bus.h_lock)) begin
          c_win      = rr_c;
          h_win      = rr_h;
          state_d    = RR;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_MAX && bus.c_req) begin
          c_win   = 1'b1;
          state_d = YIELD;
        end else begin
          h_win = 1'b1;
          if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      YIELD: begin
        c_win      = bus.c_req;
        h_win      = bus.h_req & ~bus.c_req;
        state_d    = RR;
        lock_cnt_d = '0;
      end
      default: begin
        state_d    = RR;
        lock_cnt_d = '0;
      end
    endcase
    if (c_win) last_d = 1'b0;
    else if (h_win) last_d = 1'b1;
  end

  // Grants are suppressed during reset so no memory write can land on a reset edge.
  always_comb begin
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    if (c_win) begin
      mem_addr_d  = bus.c_addr;
      mem_wdata_d = bus.c_wdata;
      mem_we_d    = bus.c_we;
    end else if (h_win) begin
      mem_addr_d  = bus.h_addr;
      mem_wdata_d = bus.h_wdata;
      mem_we_d    = bus.h_we;
    end
    bus.c_gnt     = c_win & ~RST;
    bus.h_gnt     = h_win & ~RST;
    bus.mem_addr  = RST ? '0 : mem_addr_d;
    bus.mem_wdata = RST ? '0 : mem_wdata_d;
    bus.mem_we    = mem_we_d & ~RST;
    bus.c_stall   = bus.c_req & ~bus.c_gnt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RR;
      last_q      <= 1'b1;
      lock_cnt_q  <= '0;
      c_rvalid_q  <= 1'b0;
      h_rvalid_q  <= 1'b0;
      c_rdata_q   <= '0;
      h_rdata_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      c_rvalid_q <= bus.c_gnt & ~bus.c_we;
      h_rvalid_q <= bus.h_gnt & ~bus.h_we;
      if (bus.c_gnt && !bus.c_we) c_rdata_q <= bus.mem_rdata;
      if (bus.h_gnt && !bus.h_we) h_rdata_q <= bus.mem_rdata;
      if (bus.c_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.c_rvalid = c_rvalid_q;
  assign bus.h_rvalid = h_rvalid_q;
  assign bus.c_rdata  = c_rdata_q;
  assign bus.h_rdata  = h_rdata_q;
  assign stall_cnt    = stall_cnt_q;
  assign lock_active  = (state_q == LOCKED);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle grant checks plus a read-data scoreboard
// that a separate monitor drains whenever either port presents rvalid.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] stallCnt;
  logic        lockActive;
  logic [7:0]  mem [16];
  logic [7:0]  cExpQ [$];
  logic [7:0]  hExpQ [$];
  int          testsRun;
  int          testsFailed;

  dmem_arbiter_if #(.AW(4), .DW(8)) bus ();

  dmem_arbiter #(.AW(4), .DW(8), .MAX_LOCK(8), .SCW(16)) dut (
    .CLK        (clk),
    .RST        (rst),
    .bus        (bus),
    .stall_cnt  (stallCnt),
    .lock_active(lockActive)
  );

  // Behavioural single-port memory: synchronous write, combinational read.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearInputs();
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
    bus.h_req = 0; bus.h_lock = 0; bus.h_we = 0; bus.h_addr = 0; bus.h_wdata = 0;
  endtask

  // Drives one cycle of requests at the negedge, checks the combinational grants,
  // and queues the expected read data for whichever port should win a read.
  task automatic applyStimulus(
    input logic cr, input logic cw, input logic [3:0] ca, input logic [7:0] cd,
    input logic hr, input logic hl, input logic hw, input logic [3:0] ha, input logic [7:0] hd,
    input logic expC, input logic expH, input logic expL, input logic [7:0] expData);
    @(negedge clk);
    bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
    bus.h_req = hr; bus.h_lock = hl; bus.h_we = hw; bus.h_addr = ha; bus.h_wdata = hd;
    #2;
    checkOutput("c_gnt", 32'(bus.c_gnt), 32'(expC));
    checkOutput("h_gnt", 32'(bus.h_gnt), 32'(expH));
    checkOutput("lock_active", 32'(lockActive), 32'(expL));
    checkOutput("c_stall", 32'(bus.c_stall), 32'(cr & ~expC));
    if (expC && !cw) cExpQ.push_back(expData);
    if (expH && !hw) hExpQ.push_back(expData);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    clearInputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every presented read is matched against the head of its port's queue.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (bus.c_rvalid) begin
        if (cExpQ.size() == 0) checkOutput("c_rvalid_unexpected", 32'(1), 32'(0));
        else begin
          exp = cExpQ.pop_front();
          checkOutput("c_rdata", 32'(bus.c_rdata), 32'(exp));
        end
      end
      if (bus.h_rvalid) begin
        if (hExpQ.size() == 0) checkOutput("h_rvalid_unexpected", 32'(1), 32'(0));
        else begin
          exp = hExpQ.pop_front();
          checkOutput("h_rdata", 32'(bus.h_rdata), 32'(exp));
        end
      end
    end
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    clearInputs();
    rst = 1'b1;
    bus.c_req = 1'b1;
    bus.h_req = 1'b1;
    #3;
    checkOutput("rst_c_gnt", 32'(bus.c_gnt), 32'(0));
    checkOutput("rst_h_gnt", 32'(bus.h_gnt), 32'(0));
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'(0));
    @(negedge clk);
    checkOutput("rst_c_rvalid", 32'(bus.c_rvalid), 32'(0));
    checkOutput("rst_c_rdata", 32'(bus.c_rdata), 32'(0));
    checkOutput("rst_stall_cnt", 32'(stallCnt), 32'(0));
    checkOutput("rst_lock_active", 32'(lockActive), 32'(0));
    clearInputs();
    rst = 1'b0;

    // Preload mem[3] through the host, then restart so the first tie goes to the core.
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 4'd3, 8'h5A, 0, 1, 0, 0);
    doReset();

    // Plain core read with the host idle.
    applyStimulus(1, 0, 4'd3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h5A);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_stall_cnt", 32'(stallCnt), 32'(0));
    checkOutput("t1_rdata_hold", 32'(bus.c_rdata), 32'(8'h5A));
    checkOutput("t1_rvalid_one_cycle", 32'(bus.c_rvalid), 32'(0));

    // Continuous contention with no lock alternates starting with the core.
    doReset();
    for (int k = 0; k < 4; k++)
      applyStimulus(1, 1, 4'd1, 8'h11, 1, 0, 1, 4'd2, 8'h22, (k % 2 == 0), (k % 2 == 1), 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_stall_cnt", 32'(stallCnt), 32'(2));
    checkOutput("t2_idle_mem_we", 32'(bus.mem_we), 32'(0));
    checkOutput("t2_idle_mem_addr", 32'(bus.mem_addr), 32'(0));
    checkOutput("t2_mem1", 32'(mem[1]), 32'(8'h11));
    checkOutput("t2_mem2", 32'(mem[2]), 32'(8'h22));

    // Host burst with lock; core waits from cycle 2 and is let in after 8 host grants.
    for (int k = 0; k < 11; k++) begin
      logic [3:0] ha;
      ha = (k <= 7) ? 4'(k) : ((k <= 9) ? 4'd8 : 4'd9);
      applyStimulus((k >= 2 && k <= 8), 0, 4'd1, 0, 1, 1, 1, ha, 8'h80 + 8'(ha),
                    (k == 8), (k != 8), (k >= 1 && k <= 8), 8'h81);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_stall_cnt", 32'(stallCnt), 32'(8));
    checkOutput("t3_mem9", 32'(mem[9]), 32'(8'h89));

    // Locked host reads with no core demand: lock count saturates, no yield.
    for (int k = 0; k < 12; k++)
      applyStimulus(0, 0, 0, 0, 1, 1, 0, 4'(k % 10), 0, 0, 1, (k != 0), 8'h80 + 8'(k % 10));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Same-address race: host write wins (last=C), core read then sees the new value.
    applyStimulus(1, 0, 4'd3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h83);
    applyStimulus(1, 0, 4'd4, 0, 1, 0, 1, 4'd4, 8'h33, 0, 1, 0, 0);
    applyStimulus(1, 0, 4'd4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h33);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_stall_cnt", 32'(stallCnt), 32'(9));

    // Reset lands right after a granted core read; a host write held through reset must not occur.
    @(negedge clk);
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 4'd5;
    #2;
    checkOutput("t6_c_gnt", 32'(bus.c_gnt), 32'(1));
    @(posedge clk);
    #1;
    checkOutput("t6_pre_rvalid", 32'(bus.c_rvalid), 32'(1));
    checkOutput("t6_pre_rdata", 32'(bus.c_rdata), 32'(8'h85));
    #1;
    rst = 1'b1;
    bus.h_req = 1; bus.h_we = 1; bus.h_addr = 4'd6; bus.h_wdata = 8'hEE;
    #1;
    checkOutput("t6_rvalid_cleared", 32'(bus.c_rvalid), 32'(0));
    checkOutput("t6_rdata_cleared", 32'(bus.c_rdata), 32'(0));
    checkOutput("t6_c_gnt_rst", 32'(bus.c_gnt), 32'(0));
    checkOutput("t6_h_gnt_rst", 32'(bus.h_gnt), 32'(0));
    checkOutput("t6_stall_cnt", 32'(stallCnt), 32'(0));
    @(posedge clk);
    #1;
    checkOutput("t6_mem_we_rst", 32'(bus.mem_we), 32'(0));
    @(negedge clk);
    clearInputs();
    rst = 1'b0;
    applyStimulus(1, 0, 4'd6, 0, 1, 0, 0, 4'd7, 0, 1, 0, 0, 8'h86);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 4'd7, 0, 0, 1, 0, 8'h87);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_mem6_untouched", 32'(mem[6]), 32'(8'h86));

    checkOutput("c_reads_outstanding", 32'(cExpQ.size()), 32'(0));
    checkOutput("h_reads_outstanding", 32'(hExpQ.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
